switch_debounce_and_led: RTL and testbench
==========================================

// Module: switch_debounce_and_led
// PURPOSE
// - Input end of the switch-to-LED path: synchronises and debounces two raw board
//   switches, drives o_LED_0 with the AND of the clean levels and emits a one-cycle
//   pulse when that AND rises.
// - Sits between the board switch pins and any LED or control logic.
// - Replaces the direct combinational switch-to-LED path, which shows contact bounce.
// PARAMETERS
// - DEBOUNCE_CYCLES  250000  consecutive clocks a new level must hold (10 ms @ 25 MHz); legal >= 1
// - SYNC_STAGES      2       synchroniser flops per switch; legal >= 2
// PORTS
// - i_Clk          in   1  system clock; the only clock; all flops on rising edge
// - i_Reset        in   1  asynchronous, active-high reset
// - i_Switch_0     in   1  raw switch 0, asynchronous to i_Clk, bouncy
// - i_Switch_1     in   1  raw switch 1, asynchronous to i_Clk, bouncy
// - o_Switch_0_Db  out  1  debounced level of switch 0
// - o_Switch_1_Db  out  1  debounced level of switch 1
// - o_LED_0        out  1  o_Switch_0_Db & o_Switch_1_Db
// - o_LED_Rise     out  1  one-cycle pulse when o_LED_0 goes 0->1
// BEHAVIOUR
// - Reset: asserting i_Reset at any time, mid-count included, immediately clears:
//   - all synchroniser flops, counters and stable flops
//   - every output (o_Switch_*_Db, o_LED_0, o_LED_Rise)
// - After reset release: a switch held high is treated as a new level and debounced
//   normally.
// - Synchroniser: SYNC_STAGES-deep flop chain per switch; only the last stage (sync_n)
//   feeds logic.
// - Debounce counter, per switch, width $clog2(DEBOUNCE_CYCLES+1), unsigned:
//   - sync_n == stable: counter <= 0.
//   - sync_n != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync_n, counter <= 0.
//   - Otherwise: counter <= counter + 1.
//   - Counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
// - Glitches: a mismatch shorter than DEBOUNCE_CYCLES clocks restarts the count; stable
//   is unchanged.
// - Latency: after the raw input settles, o_Switch_n_Db changes exactly
//   SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that captures the
//   new level.
// - DEBOUNCE_CYCLES = 1: a one-cycle mismatch updates stable; latency is SYNC_STAGES + 1.
// - o_LED_0: combinational AND of the two stable flops (registered sources, no
//   glitches). Changes in the same cycle as the debounced output that causes it.
// - o_LED_Rise: registered previous LED value led_q; pulse = o_LED_0 & ~led_q.
//   - High for exactly the first cycle o_LED_0 is 1.
//   - Not asserted on reset release.
// - Simultaneous: both switches qualifying on the same edge gives one LED rise and one
//   pulse.
// - One switch falling while the other rises on the same edge: o_LED_0 stays 0, no pulse.
// - No handshake; all outputs are level/pulse and valid every cycle.
// STRUCTURE
// - Sub-module switch_debounce (params DEBOUNCE_CYCLES, SYNC_STAGES; ports i_Clk,
//   i_Reset, i_Switch, o_Switch_Db):
//   - synchroniser + counter + stable flop
//   - instantiated twice
// - Top level holds the AND, led_q and the rise pulse.
// - Shared package switch_pkg:
//   - DEBOUNCE_CYCLES_DEFAULT = 250000
//   - SYNC_STAGES_DEFAULT = 2
//   - function clog2_counter_width(cycles)
// TESTING (bench overrides DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2)
// 1. Reset: pulse i_Reset with both switches 1.
//    -> all outputs 0 during reset; both Db outputs rise 6 edges after release;
//       o_LED_Rise high exactly 1 cycle.
// 2. Clean press: i_Switch_0 = 1 held, i_Switch_1 = 0.
//    -> o_Switch_0_Db = 1 on edge 6; o_LED_0 stays 0; o_LED_Rise never fires.
// 3. Bounce: i_Switch_1 toggles 1,0,1,0 at one-cycle intervals, then 1 for 3 cycles,
//    then 0.
//    -> o_Switch_1_Db stays 0 throughout.
// 4. Full AND truth table: 00, 01, 10, 11, each held 10 cycles.
//    -> o_LED_0 = 0,0,0,1; exactly one o_LED_Rise pulse, 6 edges into the 11 phase.
// 5. Simultaneous release and press: from 10, set 01 in the same cycle.
//    -> Db outputs swap on the same edge; o_LED_0 stays 0; no pulse.
// 6. Mid-count reset: from 00, set 11; assert i_Reset at count 2, release, keep 11.
//    -> outputs 0 during reset; LED rises 6 edges after release; one pulse total.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared constants and helpers for the switch debounce path.
package switch_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
    localparam int SYNC_STAGES_DEFAULT     = 2;

    // Counter wide enough to hold the value DEBOUNCE_CYCLES.
    function automatic int clog2_counter_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_debounce_and_led_if.sv
// Switch inputs and debounced/LED outputs of the switch-to-LED path.
interface switch_debounce_and_led_if;

    logic i_Switch_0;
    logic i_Switch_1;
    logic o_Switch_0_Db;
    logic o_Switch_1_Db;
    logic o_LED_0;
    logic o_LED_Rise;

    modport master (
        output i_Switch_0,
        output i_Switch_1,
        input  o_Switch_0_Db,
        input  o_Switch_1_Db,
        input  o_LED_0,
        input  o_LED_Rise
    );

    modport slave (
        input  i_Switch_0,
        input  i_Switch_1,
        output o_Switch_0_Db,
        output o_Switch_1_Db,
        output o_LED_0,
        output o_LED_Rise
    );

endinterface

// File: rtl/switch_debounce_and_led_debounce.sv
// One raw switch: synchroniser chain, consecutive-mismatch counter and stable flop.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Switch_Db
);

    localparam int                CNT_W   = clog2_counter_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_n;
    logic [CNT_W-1:0]       count;
    logic                   stable;

    assign sync_n = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_Switch};
        end
    end

    // Any return to the stable level restarts the count, so bounces never qualify.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            count  <= '0;
            stable <= 1'b0;
        end else if (sync_n == stable) begin
            count <= '0;
        end else if (count == CNT_MAX) begin
            stable <= sync_n;
            count  <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign o_Switch_Db = stable;

endmodule

// File: rtl/switch_debounce_and_led.sv
// Two debounced switches ANDed onto an LED, with a one-cycle pulse on each LED rise.
module switch_debounce_and_led
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic                           i_Clk,
    input  logic                           i_Reset,
    switch_debounce_and_led_if.slave       sw
);

    logic switch_0_db;
    logic switch_1_db;
    logic led;
    logic led_q;

    switch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_debounce_0 (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_Switch    (sw.i_Switch_0),
        .o_Switch_Db (switch_0_db)
    );

    switch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_debounce_1 (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_Switch    (sw.i_Switch_1),
        .o_Switch_Db (switch_1_db)
    );

    // Both sources are flops, so the AND is glitch-free.
    assign led = switch_0_db & switch_1_db;

    // led_q clears in reset, so the first LED cycle after release still pulses.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led;
        end
    end

    assign sw.o_Switch_0_Db = switch_0_db;
    assign sw.o_Switch_1_Db = switch_1_db;
    assign sw.o_LED_0       = led;
    assign sw.o_LED_Rise    = led & ~led_q;

endmodule

// File: tb/tb_switch_debounce_and_led.sv
// Directed bench for switch_debounce_and_led with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_switch_debounce_and_led;

    logic i_Clk;
    logic i_Reset;
    int   errors;
    int   checks;
    int   rise_count;
    int   led_count;

    switch_debounce_and_led_if sw_if ();

    switch_debounce_and_led #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .sw      (sw_if.slave)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic s0, input logic s1);
        sw_if.i_Switch_0 = s0;
        sw_if.i_Switch_1 = s1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic db0, input logic db1,
                             input logic led, input logic rise);
        check_output({tag, "_db0"},  sw_if.o_Switch_0_Db, db0);
        check_output({tag, "_db1"},  sw_if.o_Switch_1_Db, db1);
        check_output({tag, "_led"},  sw_if.o_LED_0,       led);
        check_output({tag, "_rise"}, sw_if.o_LED_Rise,    rise);
    endtask

    // Hand-computed LED level at the end of each truth-table phase.
    logic [1:0] tt_pattern [4];
    logic       tt_led     [4];

    initial begin
        errors  = 0;
        checks  = 0;
        tt_pattern = '{2'b00, 2'b01, 2'b10, 2'b11};
        tt_led     = '{1'b0, 1'b0, 1'b0, 1'b1};

        // Reset held with both switches high.
        i_Reset = 1'b1;
        apply_stimulus(1'b1, 1'b1);
        tick();
        tick();
        tick();
        check_all("t1_in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        i_Reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_output("t1_db0_before_6", sw_if.o_Switch_0_Db, 1'b0);
        end
        tick();
        check_all("t1_edge6", 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check_all("t1_edge7", 1'b1, 1'b1, 1'b1, 1'b0);

        // Clean press of switch 0 from an all-low state.
        apply_stimulus(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check_all("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        rise_count = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            rise_count += int'(sw_if.o_LED_Rise);
            if (i == 5) check_output("t2_db0_edge5", sw_if.o_Switch_0_Db, 1'b0);
            if (i == 6) check_all("t2_edge6", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check_output("t2_no_rise", rise_count, 0);

        // Bouncing switch 1: single-cycle toggles then a 3-cycle high.
        led_count = 0;
        apply_stimulus(1'b1, 1'b1); tick();
        apply_stimulus(1'b1, 1'b0); tick();
        apply_stimulus(1'b1, 1'b1); tick();
        apply_stimulus(1'b1, 1'b0); tick();
        apply_stimulus(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            led_count += int'(sw_if.o_Switch_1_Db);
        end
        apply_stimulus(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            led_count += int'(sw_if.o_Switch_1_Db);
        end
        check_output("t3_db1_never_high", led_count, 0);
        check_output("t3_db0_held", sw_if.o_Switch_0_Db, 1'b1);

        // AND truth table, 10 cycles per pattern.
        rise_count = 0;
        for (int p = 0; p < 4; p++) begin
            apply_stimulus(tt_pattern[p][1], tt_pattern[p][0]);
            for (int i = 1; i <= 10; i++) begin
                tick();
                rise_count += int'(sw_if.o_LED_Rise);
                if (p == 3 && i == 5) check_output("t4_rise_edge5", sw_if.o_LED_Rise, 1'b0);
                if (p == 3 && i == 6) check_output("t4_rise_edge6", sw_if.o_LED_Rise, 1'b1);
            end
            check_output("t4_led_phase", sw_if.o_LED_0, tt_led[p]);
        end
        check_output("t4_one_rise", rise_count, 1);

        // Simultaneous release of switch 0 and press of switch 1.
        apply_stimulus(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check_all("t5_start_10", 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1);
        rise_count = 0;
        led_count  = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            rise_count += int'(sw_if.o_LED_Rise);
            led_count  += int'(sw_if.o_LED_0);
            if (i == 5) check_all("t5_edge5", 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 6) check_all("t5_edge6", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check_output("t5_led_never_high", led_count, 0);
        check_output("t5_no_rise", rise_count, 0);

        // Reset in the middle of a debounce count.
        apply_stimulus(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check_all("t6_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        i_Reset = 1'b1;
        #1;
        check_all("t6_reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_all("t6_in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        i_Reset = 1'b0;
        rise_count = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            rise_count += int'(sw_if.o_LED_Rise);
            if (i == 5) check_output("t6_led_edge5", sw_if.o_LED_0, 1'b0);
            if (i == 6) check_all("t6_edge6", 1'b1, 1'b1, 1'b1, 1'b1);
        end
        check_output("t6_one_rise", rise_count, 1);
        check_output("t6_led_held", sw_if.o_LED_0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
